alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Feeds an external ALU through a multi-pass operation. A request supplies
// an op code, two operands and a pass count. Each EXEC cycle feeds the ALU
// result back into operand A while B and the op code stay fixed. After the
// final pass, the result and the ALU's registered flags are returned over a
// valid/ready response handshake.
//
// Configuration macro: ALU_SEQ_MULTIPASS_EN
//   defined   : req_count is honoured (req_count+1 passes, 1..16)
//   undefined : req_count is ignored, EXEC is exactly one cycle
//
// Ports
//   clk          in   1   system clock, rising edge
//   rst          in   1   asynchronous active-high reset
//   req_valid    in   1   request present
//   req_ready    out  1   sequencer idle, request will be accepted
//   req_fun_sel  in   5   ALU op code, passed through unmodified
//   req_a/req_b  in  16   initial ALU operands
//   req_count    in   4   extra passes (total = req_count+1)
//   req_wf       in   1   flag-write enable for every pass
//   alu_a/alu_b  out 16   operands to the ALU
//   alu_fun_sel  out  5   ALU op code
//   alu_wf       out  1   ALU flag-write strobe
//   alu_out      in  16   combinational ALU result
//   alu_flags    in   4   registered ALU flags {Z, C, N, O}
//   rsp_valid    out  1   response present
//   rsp_ready    in   1   response accepted
//   rsp_result   out 16   final ALU result
//   rsp_flags    out  4   ALU flags after the final pass
// -----------------------------------------------------------------------------
module alu_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_fun_sel,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [3:0]  req_count,
  input  logic        req_wf,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [4:0]  alu_fun_sel,
  output logic        alu_wf,
  input  logic [15:0] alu_out,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [3:0]  rsp_flags
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE, RESP} state_t;

  state_t state;
  logic   last_pass;

`ifdef ALU_SEQ_MULTIPASS_EN
  // Remaining passes after the current one; zero marks the final pass.
  logic [3:0] pass_cnt;
  assign last_pass = (pass_cnt == 4'd0);
`else
  // Single-pass build: the pass count has no effect.
  logic unused_count;
  assign unused_count = ^req_count;
  assign last_pass    = 1'b1;
`endif

  // alu_wf doubles as the latched request flag-write enable: it is loaded
  // from req_wf on acceptance and held for the whole of EXEC.
  // NOTE: all state and registered outputs use non-blocking assignments so
  // every register samples pre-edge values, e.g. alu_a <= alu_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_result  <= 16'h0000;
      rsp_flags   <= 4'h0;
      alu_a       <= 16'h0000;
      alu_b       <= 16'h0000;
      alu_fun_sel <= 5'd0;
      alu_wf      <= 1'b0;
`ifdef ALU_SEQ_MULTIPASS_EN
      pass_cnt    <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            alu_a       <= req_a;
            alu_b       <= req_b;
            alu_fun_sel <= req_fun_sel;
            alu_wf      <= req_wf;
            req_ready   <= 1'b0;
            state       <= EXEC;
`ifdef ALU_SEQ_MULTIPASS_EN
            pass_cnt    <= req_count;
`endif
          end
        end

        EXEC: begin
          // Feed the result back; B and the op code stay put.
          alu_a <= alu_out;
          if (last_pass) begin
            rsp_result <= alu_out;
            alu_wf     <= 1'b0;
            state      <= DONE;
          end
`ifdef ALU_SEQ_MULTIPASS_EN
          else begin
            pass_cnt <= pass_cnt - 4'd1;
          end
`endif
        end

        // The ALU latched its flags on the final EXEC edge, so they are
        // valid here regardless of whether this request wrote them.
        DONE: begin
          rsp_flags <= alu_flags;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_sequencer
//
// Self-checking bench for alu_sequencer with a small ALU model
// (10100 = A+B, 11011 = A<<1, others pass A) and registered {Z,C,N,O} flags.
// Expected values follow the ALU_SEQ_MULTIPASS_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_fun_sel = '0;
  logic [15:0] req_a = '0;
  logic [15:0] req_b = '0;
  logic [3:0]  req_count = '0;
  logic        req_wf = 1'b0;
  logic [15:0] alu_a, alu_b;
  logic [4:0]  alu_fun_sel;
  logic        alu_wf;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags = 4'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] OP_ADD = 5'b10100;
  localparam logic [4:0] OP_LSL = 5'b11011;

  alu_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_fun_sel (req_fun_sel),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_count   (req_count),
    .req_wf      (req_wf),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_fun_sel (alu_fun_sel),
    .alu_wf      (alu_wf),
    .alu_out     (alu_out),
    .alu_flags   (alu_flags),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_flags   (rsp_flags)
  );

  always #5 clk = ~clk;

  // ALU model: combinational result, flags registered when alu_wf is high.
  logic [16:0] alu_sum;
  logic        alu_c, alu_o;
  always_comb begin
    alu_sum = '0;
    alu_out = alu_a;
    alu_c   = 1'b0;
    alu_o   = 1'b0;
    case (alu_fun_sel)
      OP_ADD: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out = alu_sum[15:0];
        alu_c   = alu_sum[16];
        alu_o   = (alu_a[15] == alu_b[15]) && (alu_sum[15] != alu_a[15]);
      end
      OP_LSL: begin
        alu_out = {alu_a[14:0], 1'b0};
        alu_c   = alu_a[15];
        alu_o   = alu_a[15] ^ alu_a[14];
      end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (alu_wf)
      alu_flags <= {(alu_out == 16'h0000), alu_c, alu_out[15], alu_o};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, then optionally hold rsp_ready low for `stall` cycles
  // while a second request is offered (it must be ignored).
  task automatic run_req(input string tag, input logic [4:0] fs, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] cnt, input logic wf,
                         input logic [15:0] exp_res, input logic [3:0] exp_flags,
                         input int exp_lat, input int exp_wf_cycles, input int stall);
    int lat;
    int wf_cycles;
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid   = 1'b1;
    req_fun_sel = fs;
    req_a       = a;
    req_b       = b;
    req_count   = cnt;
    req_wf      = wf;
    rsp_ready   = (stall == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check({tag, "_alu_b"}, 32'(alu_b), 32'(b));
    check({tag, "_alu_fs"}, 32'(alu_fun_sel), 32'(fs));
    lat = 0;
    wf_cycles = 0;
    while (!rsp_valid && lat < 40) begin
      if (alu_wf) wf_cycles++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_wf_cycles"}, 32'(wf_cycles), 32'(exp_wf_cycles));
    check({tag, "_result"}, 32'(rsp_result), 32'(exp_res));
    check({tag, "_flags"}, 32'(rsp_flags), 32'(exp_flags));
    check({tag, "_busy"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      if (i == 2) req_valid = 1'b1;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_result"}, 32'(rsp_result), 32'(exp_res));
      check({tag, "_hold_flags"}, 32'(rsp_flags), 32'(exp_flags));
      check({tag, "_hold_busy"}, 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
    check({tag, "_idle"}, 32'(req_ready), 32'd1);
    check({tag, "_wf_idle"}, 32'(alu_wf), 32'd0);
    check({tag, "_alu_fs_hold"}, 32'(alu_fun_sel), 32'(fs));
    rsp_ready = 1'b0;
  endtask

  // Build-dependent expectations, computed by hand.
`ifdef ALU_SEQ_MULTIPASS_EN
  localparam logic [15:0] T1_RES = 16'h0010;  // 1 << 4 passes
  localparam int          T1_LAT = 5;
  localparam int          T1_WF  = 4;
  localparam logic [15:0] T3_RES = 16'h1436;  // 0x1234 + 2*0x0101
  localparam int          T3_LAT = 3;
  localparam int          T3_WF  = 2;
  localparam logic [15:0] T5_RES = 16'h0010;  // 0 + 16*1
  localparam int          T5_LAT = 17;
  localparam int          T5_WF  = 16;
`else
  localparam logic [15:0] T1_RES = 16'h0002;
  localparam int          T1_LAT = 2;
  localparam int          T1_WF  = 1;
  localparam logic [15:0] T3_RES = 16'h1335;
  localparam int          T3_LAT = 2;
  localparam int          T3_WF  = 1;
  localparam logic [15:0] T5_RES = 16'h0001;
  localparam int          T5_LAT = 2;
  localparam int          T5_WF  = 1;
`endif

  initial begin
    bit seen_valid;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'h0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'h0);
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_b", 32'(alu_b), 32'h0);
    check("rst_alu_fs", 32'(alu_fun_sel), 32'h0);
    check("rst_alu_wf", 32'(alu_wf), 32'h0);

    // Shift-left chain: Z clear.
    run_req("lsl_chain", OP_LSL, 16'h0001, 16'h0000, 4'd3, 1'b1,
            T1_RES, 4'b0000, T1_LAT, T1_WF, 0);
    // Add wrapping to zero: Z and C set, single pass.
    run_req("add_wrap", OP_ADD, 16'hFFFF, 16'h0001, 4'd0, 1'b1,
            16'h0000, 4'b1100, 2, 1, 0);
    // No flag write: previous flags must be returned unchanged.
    run_req("no_wf", OP_LSL, 16'h4000, 16'h0000, 4'd0, 1'b0,
            16'h8000, 4'b1100, 2, 0, 0);
    // Maximum pass count.
    run_req("max_count", OP_ADD, 16'h0000, 16'h0001, 4'd15, 1'b1,
            T5_RES, 4'b0000, T5_LAT, T5_WF, 0);
    // Back-pressured response with an ignored second request.
    run_req("stall", OP_ADD, 16'h1234, 16'h0101, 4'd1, 1'b1,
            T3_RES, 4'b0000, T3_LAT, T3_WF, 5);

    // Reset during EXEC of a long request.
    @(negedge clk);
    req_valid   = 1'b1;
    req_fun_sel = OP_LSL;
    req_a       = 16'h0001;
    req_b       = 16'h0000;
    req_count   = 4'd7;
    req_wf      = 1'b1;
    rsp_ready   = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midrst_wf_before", 32'(alu_wf), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_wf_async", 32'(alu_wf), 32'd0);
    check("midrst_ready_async", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen_valid = 1'b1;
    end
    check("midrst_no_rsp", 32'(seen_valid), 32'd0);
    check("midrst_ready_after", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
